usb2_ext_in_packetizer: RTL and testbench



---
 rtl/usb2_ext_in_packetizer.sv | 159 +++++++++++++++
 tb/tb_usb2_ext_in_packetizer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ext_in_packetizer.sv
// Packs an ext_clk byte stream into bulk IN packets in the endpoint RAM and requests commits.
// Optional USB2_EXT_IN_ZLP_EN: follow a full packet closed by s_last with a zero-length packet.
module usb2_ext_in_packetizer #(
    parameter int unsigned MAX_PKT       = 512,
    parameter int unsigned FLUSH_TIMEOUT = 1024
) (
    input  logic       ext_clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [8:0] ext_buf_in_addr,
    output logic [7:0] ext_buf_in_data,
    output logic       ext_buf_in_wren,
    input  logic       ext_buf_in_ready,
    output logic       ext_buf_in_commit,
    output logic [9:0] ext_buf_in_commit_len,
    input  logic       ext_buf_in_commit_ack,
    output logic [15:0] pkt_count
);

    localparam int unsigned TW = $clog2(FLUSH_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FLUSH_TIMEOUT - 1);
    localparam logic [9:0] CNT_FULL = 10'(MAX_PKT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETTLE,
        ST_COMMIT,
        ST_ACKWAIT
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wren_q, wren_d;
    logic [15:0]   pkt_q, pkt_d;
    logic          accept;
    logic          fills;

    assign s_ready = (state_q == ST_FILL) && (cnt_q < CNT_FULL);
    assign accept  = s_valid && s_ready;
    assign fills   = (cnt_q + 10'd1) == CNT_FULL;

`ifdef USB2_EXT_IN_ZLP_EN
    logic zlp_q, zlp_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        pkt_d   = pkt_q;
`ifdef USB2_EXT_IN_ZLP_EN
        zlp_d   = zlp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                timer_d = '0;
                if (ext_buf_in_ready) begin
`ifdef USB2_EXT_IN_ZLP_EN
                    // Pending ZLP skips filling and commits with cnt==0.
                    if (zlp_q) begin
                        zlp_d   = 1'b0;
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_FILL;
                    end
`else
                    state_d = ST_FILL;
`endif
                end
            end
            ST_FILL: begin
                if (accept) begin
                    addr_d  = cnt_q[8:0];
                    data_d  = s_data;
                    wren_d  = 1'b1;
                    cnt_d   = cnt_q + 10'd1;
                    timer_d = '0;
                    if (fills || s_last) begin
                        state_d = ST_SETTLE;
                    end
`ifdef USB2_EXT_IN_ZLP_EN
                    if (fills && s_last) begin
                        zlp_d = 1'b1;
                    end
`endif
                end else if (cnt_q != 10'd0) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d = ST_SETTLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: state_d = ST_COMMIT;
            ST_COMMIT: begin
                if (ext_buf_in_commit_ack) begin
                    pkt_d   = pkt_q + 16'd1;
                    state_d = ST_ACKWAIT;
                end
            end
            ST_ACKWAIT: begin
                if (!ext_buf_in_commit_ack) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            pkt_q   <= pkt_d;
        end
    end

`ifdef USB2_EXT_IN_ZLP_EN
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            zlp_q <= 1'b0;
        end else begin
            zlp_q <= zlp_d;
        end
    end
`endif

    assign ext_buf_in_addr       = addr_q;
    assign ext_buf_in_data       = data_q;
    assign ext_buf_in_wren       = wren_q;
    assign ext_buf_in_commit     = (state_q == ST_COMMIT);
    assign ext_buf_in_commit_len = (state_q == ST_COMMIT) ? cnt_q : 10'd0;
    assign pkt_count             = pkt_q;

endmodule

// File: tb/tb_usb2_ext_in_packetizer.sv
// Randomized scoreboard bench for usb2_ext_in_packetizer; a packet-level model predicts
// RAM writes and commits (length and cycle) which a separate monitor checks.
module tb_usb2_ext_in_packetizer;

    localparam int MAX_PKT = 512;
    localparam int FT      = 16;

    logic        ext_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [8:0]  ext_buf_in_addr;
    logic [7:0]  ext_buf_in_data;
    logic        ext_buf_in_wren;
    logic        ext_buf_in_ready = 1'b0;
    logic        ext_buf_in_commit;
    logic [9:0]  ext_buf_in_commit_len;
    logic        ext_buf_in_commit_ack = 1'b0;
    logic [15:0] pkt_count;

    usb2_ext_in_packetizer #(.MAX_PKT(MAX_PKT), .FLUSH_TIMEOUT(FT)) dut (
        .ext_clk(ext_clk),
        .reset_n(reset_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .ext_buf_in_addr(ext_buf_in_addr),
        .ext_buf_in_data(ext_buf_in_data),
        .ext_buf_in_wren(ext_buf_in_wren),
        .ext_buf_in_ready(ext_buf_in_ready),
        .ext_buf_in_commit(ext_buf_in_commit),
        .ext_buf_in_commit_len(ext_buf_in_commit_len),
        .ext_buf_in_commit_ack(ext_buf_in_commit_ack),
        .pkt_count(pkt_count)
    );

    always #5 ext_clk = ~ext_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge ext_clk) cyc <= cyc + 1;

    // Scoreboard: expected writes {addr, data}, expected commit lengths and cycles (-1 = any).
    logic [16:0] exp_w[$];
    int          exp_len[$];
    int          exp_cyc[$];
    int          cur_len = 0;
    int          idle_cnt = 0;
    int          exp_pkts = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void close_pkt(input int at_cyc);
        exp_len.push_back(cur_len);
        exp_cyc.push_back(at_cyc + 2);
        exp_pkts++;
        cur_len  = 0;
        idle_cnt = 0;
    endfunction

    // Reference model: packet boundaries from byte count, s_last and idle run length.
    always @(negedge ext_clk) begin
        if (!reset_n) begin
            exp_w.delete();
            exp_len.delete();
            exp_cyc.delete();
            cur_len  = 0;
            idle_cnt = 0;
            exp_pkts = 0;
        end else if (s_valid && s_ready) begin
            exp_w.push_back({cur_len[8:0], s_data});
            cur_len++;
            idle_cnt = 0;
            if (cur_len == MAX_PKT || s_last) begin
`ifdef USB2_EXT_IN_ZLP_EN
                if (s_last && cur_len == MAX_PKT) begin
                    close_pkt(cyc);
                    exp_len.push_back(0);
                    exp_cyc.push_back(-1);
                    exp_pkts++;
                end else begin
                    close_pkt(cyc);
                end
`else
                close_pkt(cyc);
`endif
            end
        end else if (cur_len > 0) begin
            idle_cnt++;
            if (idle_cnt == FT) close_pkt(cyc);
        end
    end

    // Monitor
    logic commit_prev = 1'b0;
    always @(negedge ext_clk) begin
        if (!reset_n) begin
            commit_prev = 1'b0;
        end else begin
            if (ext_buf_in_wren) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_wren", 1, 0);
                end else begin
                    chk("wr_addr_data", {ext_buf_in_addr, ext_buf_in_data}, exp_w.pop_front());
                end
            end
            if (ext_buf_in_commit && !commit_prev) begin
                if (exp_len.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    int l, c;
                    l = exp_len.pop_front();
                    c = exp_cyc.pop_front();
                    chk("commit_len", ext_buf_in_commit_len, l);
                    if (c >= 0) chk("commit_cycle", cyc, c);
                end
            end
            commit_prev = ext_buf_in_commit;
        end
    end

    // Ack responder: ack three cycles into a commit, drop once commit falls.
    initial begin
        int dly = 0;
        forever begin
            @(negedge ext_clk);
            if (!reset_n) begin
                ext_buf_in_commit_ack = 1'b0;
                dly = 0;
            end else if (ext_buf_in_commit && !ext_buf_in_commit_ack) begin
                dly++;
                if (dly == 3) ext_buf_in_commit_ack = 1'b1;
            end else if (!ext_buf_in_commit && ext_buf_in_commit_ack) begin
                ext_buf_in_commit_ack = 1'b0;
                dly = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge ext_clk);
            done = s_ready;
            @(posedge ext_clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge ext_clk);
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        s_valid = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge ext_clk);
            done = (exp_len.size() == 0) && (cur_len == 0) && !ext_buf_in_commit;
        end
        if (!done) chk("drain_timeout", 0, 1);
        idle(3);
        chk("pkt_count", pkt_count, exp_pkts & 16'hffff);
    endtask

    task automatic check_zero();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_addr", ext_buf_in_addr, 0);
        chk("rst_data", ext_buf_in_data, 0);
        chk("rst_wren", ext_buf_in_wren, 0);
        chk("rst_commit", ext_buf_in_commit, 0);
        chk("rst_commit_len", ext_buf_in_commit_len, 0);
        chk("rst_pkt_count", pkt_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int r;
        int base;
        bit lst;
        #7;
        check_zero();
        @(negedge ext_clk);
        reset_n = 1'b1;
        @(posedge ext_clk);
        #1;

        // Backpressure: buffer not ready, stream pending.
        s_valid = 1'b1;
        s_data  = 8'h5a;
        for (int i = 0; i < 100; i++) begin
            @(negedge ext_clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_wren", ext_buf_in_wren, 0);
        end
        @(posedge ext_clk);
        #1;
        ext_buf_in_ready = 1'b1;
        @(negedge ext_clk);
        chk("bp_ready_rise_cycle", s_ready, 0);
        @(posedge ext_clk);
        #1;
        @(negedge ext_clk);
        chk("bp_first_accept", s_ready, 1);
        @(posedge ext_clk);
        #1;
        drain();

        // Full packet back-to-back, no s_last.
        for (int i = 0; i < MAX_PKT; i++) send_byte(8'($urandom), 1'b0);
        drain();

        // Short packet closed by s_last.
        for (int i = 0; i < 5; i++) begin
            s_data = 8'hA0;
            send_byte(8'hA0 + 8'(i), i == 4);
        end
        drain();

        // Partial packet closed by timeout.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        idle(FT + 10);
        drain();

        // Full packet with s_last on its final byte (ZLP case when enabled).
        for (int i = 0; i < MAX_PKT; i++) send_byte(8'($urandom), i == MAX_PKT - 1);
        drain();

        // Random transfers with boundary gaps around the flush timeout.
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 700);
            lst = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), lst && (i == len - 1));
                r = $urandom_range(0, 15);
                if (r == 0) idle(FT - 1);
                else if (r == 1) idle(FT);
                else if (r <= 4) idle(r - 1);
            end
            if (!lst) idle(FT + 5);
            drain();
        end

        // Empty buffer never times out.
        base = exp_pkts;
        idle(10000);
        chk("idle_no_commit", pkt_count, base & 16'hffff);

        // Reset mid-fill.
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero();
        repeat (3) @(negedge ext_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), i == 3);
        drain();

        chk("leftover_writes", exp_w.size(), 0);
        chk("leftover_commits", exp_len.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
